// File: rtl/square_motion_ctrl.sv
// Bouncing-square motion controller: moves the square once per frame in vertical blanking, with pause/single-step.
// Optional BOUNCE_COLOUR_EN: cycles COLOUR through an 8-entry RGB565 palette on every bounce.
module square_motion_ctrl #(
    parameter int unsigned H_RES = 640,
    parameter int unsigned V_RES = 480,
    parameter int unsigned SIZE  = 200,
    parameter int unsigned SPEED = 1,
    parameter int unsigned X0    = 220,
    parameter int unsigned Y0    = 140
) (
    input  logic        PCLK,
    input  logic        RESET_n,
    input  logic [9:0]  SX,
    input  logic [9:0]  SY,
    input  logic        DE,
    input  logic        PAUSE,
    input  logic        STEP_REQ,
    output logic        STEP_ACK,
    output logic [9:0]  SQ_X,
    output logic [9:0]  SQ_Y,
    output logic        SQUARE,
    output logic        BOUNCE,
    output logic [15:0] COLOUR
);

    typedef enum logic [1:0] {IDLE, MOVE_X, MOVE_Y, DONE} state_t;

    localparam logic [9:0]  X_MAX  = 10'(H_RES - SIZE);
    localparam logic [9:0]  Y_MAX  = 10'(V_RES - SIZE);
    localparam logic [10:0] SPD    = 11'(SPEED);
    localparam logic [10:0] SZ     = 11'(SIZE);
    localparam logic [9:0]  V_LINE = 10'(V_RES);

    state_t      state, state_nx;
    logic        hit, hit_q, tick;
    logic        dir_x, dir_y, bnc_x, bnc_y;
    logic        pending, step_run;
    logic [10:0] x_step, y_step;

    // Returns {flip, new_pos} for one axis update in 11-bit arithmetic.
    function automatic logic [10:0] axis_step(input logic [9:0] pos, input logic dir,
                                              input logic [9:0] lim);
        logic [10:0] sum;
        sum = {1'b0, pos} + SPD;
        if (dir) begin
            if (sum >= {1'b0, lim}) return {1'b1, lim};
            return {1'b0, sum[9:0]};
        end
        if ({1'b0, pos} <= SPD) return {1'b1, 10'd0};
        return {1'b0, pos - SPD[9:0]};
    endfunction

    // Edge-detected so a held coordinate still yields a single-cycle tick.
    assign hit    = (SY == V_LINE) && (SX == '0);
    assign tick   = hit && !hit_q;
    assign x_step = axis_step(SQ_X, dir_x, X_MAX);
    assign y_step = axis_step(SQ_Y, dir_y, Y_MAX);

    always_ff @(posedge PCLK or negedge RESET_n) begin
        if (!RESET_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (tick && (!PAUSE || pending)) state_nx = MOVE_X;
            MOVE_X:  state_nx = MOVE_Y;
            MOVE_Y:  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge RESET_n) begin
        if (!RESET_n) begin
            SQ_X     <= 10'(X0);
            SQ_Y     <= 10'(Y0);
            dir_x    <= 1'b1;
            dir_y    <= 1'b1;
            bnc_x    <= 1'b0;
            bnc_y    <= 1'b0;
            pending  <= 1'b0;
            step_run <= 1'b0;
            hit_q    <= 1'b0;
            SQUARE   <= 1'b0;
            STEP_ACK <= 1'b0;
            BOUNCE   <= 1'b0;
        end else begin
            hit_q    <= hit;
            STEP_ACK <= 1'b0;
            BOUNCE   <= 1'b0;
            SQUARE   <= DE
                        && ({1'b0, SX} >= {1'b0, SQ_X}) && ({1'b0, SX} < ({1'b0, SQ_X} + SZ))
                        && ({1'b0, SY} >= {1'b0, SQ_Y}) && ({1'b0, SY} < ({1'b0, SQ_Y} + SZ));
            if (STEP_REQ && PAUSE && !pending) pending <= 1'b1;
            case (state)
                IDLE: if (state_nx == MOVE_X) step_run <= pending;
                MOVE_X: begin
                    SQ_X  <= x_step[9:0];
                    dir_x <= dir_x ^ x_step[10];
                    bnc_x <= x_step[10];
                end
                MOVE_Y: begin
                    SQ_Y  <= y_step[9:0];
                    dir_y <= dir_y ^ y_step[10];
                    bnc_y <= y_step[10];
                end
                DONE: begin
                    BOUNCE <= bnc_x | bnc_y;
                    if (step_run) begin
                        STEP_ACK <= 1'b1;
                        pending  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef BOUNCE_COLOUR_EN
    logic [2:0] pal_idx;

    function automatic logic [15:0] palette(input logic [2:0] i);
        case (i)
            3'd0:    return 16'hFFFF;
            3'd1:    return 16'hF800;
            3'd2:    return 16'h07E0;
            3'd3:    return 16'h001F;
            3'd4:    return 16'hFFE0;
            3'd5:    return 16'h07FF;
            3'd6:    return 16'hF81F;
            default: return 16'hFD20;
        endcase
    endfunction

    always_ff @(posedge PCLK or negedge RESET_n) begin
        if (!RESET_n) begin
            pal_idx <= '0;
            COLOUR  <= 16'hFFFF;
        end else begin
            if (BOUNCE) pal_idx <= pal_idx + 3'd1;
            COLOUR <= palette(pal_idx);
        end
    end
`else
    assign COLOUR = 16'hFFFF;
`endif

endmodule

// File: tb/tb_square_motion_ctrl.sv
// Directed testbench for square_motion_ctrl at default parameters.
module tb_square_motion_ctrl;

    logic        PCLK = 1'b0;
    logic        RESET_n;
    logic [9:0]  SX, SY;
    logic        DE, PAUSE, STEP_REQ;
    logic        STEP_ACK, SQUARE, BOUNCE;
    logic [9:0]  SQ_X, SQ_Y;
    logic [15:0] COLOUR;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [9:0] x1, y2;
    logic       b3, a3, b4, a4;
    int unsigned bounce_cnt, pulse_cnt;

    square_motion_ctrl dut (
        .PCLK     (PCLK),
        .RESET_n  (RESET_n),
        .SX       (SX),
        .SY       (SY),
        .DE       (DE),
        .PAUSE    (PAUSE),
        .STEP_REQ (STEP_REQ),
        .STEP_ACK (STEP_ACK),
        .SQ_X     (SQ_X),
        .SQ_Y     (SQ_Y),
        .SQUARE   (SQUARE),
        .BOUNCE   (BOUNCE),
        .COLOUR   (COLOUR)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // One frame tick, then capture SQ_X at +1, SQ_Y at +2, pulses at +3 and +4.
    task automatic do_tick(output logic [9:0] ox1, output logic [9:0] oy2,
                           output logic ob3, output logic oa3,
                           output logic ob4, output logic oa4);
        @(negedge PCLK);
        SX = 10'd0;
        SY = 10'd480;
        @(posedge PCLK); #1;
        SX = 10'd5;
        @(posedge PCLK); #1; ox1 = SQ_X;
        @(posedge PCLK); #1; oy2 = SQ_Y;
        @(posedge PCLK); #1; ob3 = BOUNCE; oa3 = STEP_ACK;
        @(posedge PCLK); #1; ob4 = BOUNCE; oa4 = STEP_ACK;
    endtask

    task automatic pulse_step_req();
        @(negedge PCLK); STEP_REQ = 1'b1;
        @(negedge PCLK); STEP_REQ = 1'b0;
    endtask

    typedef struct {
        logic       de;
        logic [9:0] sx;
        logic [9:0] sy;
        logic       exp;
    } sq_vec_t;

    sq_vec_t sq_vecs[7] = '{
        '{1'b1, 10'd220, 10'd140, 1'b1},
        '{1'b1, 10'd419, 10'd339, 1'b1},
        '{1'b1, 10'd420, 10'd140, 1'b0},
        '{1'b1, 10'd219, 10'd140, 1'b0},
        '{1'b1, 10'd220, 10'd340, 1'b0},
        '{1'b1, 10'd220, 10'd139, 1'b0},
        '{1'b0, 10'd220, 10'd140, 1'b0}
    };

    initial begin
        RESET_n  = 1'b0;
        SX       = 10'd1;
        SY       = 10'd0;
        DE       = 1'b0;
        PAUSE    = 1'b0;
        STEP_REQ = 1'b0;
        repeat (3) @(posedge PCLK);
        @(negedge PCLK); RESET_n = 1'b1;
        @(negedge PCLK);
        check("rst_sq_x", SQ_X, 220);
        check("rst_sq_y", SQ_Y, 140);
        check("rst_square", SQUARE, 0);
        check("rst_step_ack", STEP_ACK, 0);
        check("rst_bounce", BOUNCE, 0);
        check("rst_colour", COLOUR, 16'hFFFF);

        foreach (sq_vecs[i]) begin
            @(negedge PCLK);
            DE = sq_vecs[i].de; SX = sq_vecs[i].sx; SY = sq_vecs[i].sy;
            @(negedge PCLK);
            check($sformatf("square_vec%0d", i), SQUARE, sq_vecs[i].exp);
        end
        DE = 1'b0; SX = 10'd1; SY = 10'd0;

        do_tick(x1, y2, b3, a3, b4, a4);
        check("tick1_x", x1, 221);
        check("tick1_y", y2, 141);
        check("tick1_bounce", b3, 0);
        check("tick1_ack", a3, 0);

        // Ticks 2..219: X walks to 439, Y bounces once at tick 140 and returns to 201.
        bounce_cnt = 0;
        for (int unsigned t = 2; t <= 219; t++) begin
            do_tick(x1, y2, b3, a3, b4, a4);
            if (b3) bounce_cnt++;
            if (t == 140) check("y_bounce_at_280", y2, 280);
        end
        check("run_bounce_count", bounce_cnt, 1);
        check("tick219_x", SQ_X, 439);
        check("tick219_y", SQ_Y, 201);

        do_tick(x1, y2, b3, a3, b4, a4);
        check("edge_x", x1, 440);
        check("edge_y", y2, 200);
        check("edge_bounce", b3, 1);
        check("edge_bounce_width", b4, 0);
        check("edge_ack_free_run", a3, 0);

        do_tick(x1, y2, b3, a3, b4, a4);
        check("after_edge_x", x1, 439);
        check("after_edge_y", y2, 199);
        check("after_edge_bounce", b3, 0);

        @(negedge PCLK); PAUSE = 1'b1;
        for (int unsigned t = 0; t < 3; t++) begin
            do_tick(x1, y2, b3, a3, b4, a4);
            check($sformatf("pause%0d_x", t), x1, 439);
            check($sformatf("pause%0d_y", t), y2, 199);
            check($sformatf("pause%0d_ack", t), a3, 0);
        end

        pulse_step_req();
        pulse_step_req();
        do_tick(x1, y2, b3, a3, b4, a4);
        check("step_x", x1, 438);
        check("step_y", y2, 198);
        check("step_ack", a3, 1);
        check("step_ack_width", a4, 0);

        do_tick(x1, y2, b3, a3, b4, a4);
        check("second_req_ignored_x", x1, 438);
        check("second_req_ignored_ack", a3, 0);

        // Reset while the FSM is in MOVE_Y of a step-triggered update.
        pulse_step_req();
        @(negedge PCLK); SX = 10'd0; SY = 10'd480;
        @(posedge PCLK); #1; SX = 10'd5;
        @(posedge PCLK); #1;
        check("mid_update_x", SQ_X, 437);
        RESET_n = 1'b0;
        #1;
        check("async_rst_x", SQ_X, 220);
        check("async_rst_y", SQ_Y, 140);
        check("async_rst_ack", STEP_ACK, 0);
        check("async_rst_bounce", BOUNCE, 0);
        check("async_rst_square", SQUARE, 0);
        check("async_rst_colour", COLOUR, 16'hFFFF);
        repeat (2) @(posedge PCLK);
        @(negedge PCLK); RESET_n = 1'b1;
        pulse_cnt = 0;
        for (int unsigned c = 0; c < 6; c++) begin
            @(negedge PCLK);
            if (STEP_ACK || BOUNCE) pulse_cnt++;
        end
        check("post_rst_no_pulse", pulse_cnt, 0);

        do_tick(x1, y2, b3, a3, b4, a4);
        check("post_rst_pending_clear_x", x1, 220);
        check("post_rst_pending_clear_ack", a3, 0);

        @(negedge PCLK); PAUSE = 1'b0;
        do_tick(x1, y2, b3, a3, b4, a4);
        check("post_rst_dir_x", x1, 221);
        check("post_rst_dir_y", y2, 141);
        check("final_colour", COLOUR, 16'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
